// File: rtl/lcd_instruction_tx_pkg.sv
// Shared timing constants, db word layout and sequencing states for the
// HD44780 4-bit instruction transmitter.
package lcd_pkg;

  // Cycle counts at 50 MHz
  localparam int unsigned SETUP_CYC      = 2;
  localparam int unsigned E_HIGH_CYC     = 12;
  localparam int unsigned HOLD_CYC       = 1;
  localparam int unsigned NIBBLE_GAP_CYC = 50;
  localparam int unsigned INSTR_WAIT_CYC = 2000;

  localparam int CNT_W = 16;

  // db = {RS, RW, D7..D0}
  localparam int DB_W   = 10;
  localparam int RS_BIT = 9;
  localparam int RW_BIT = 8;
  localparam int UP_HI  = 7;
  localparam int UP_LO  = 4;
  localparam int LO_HI  = 3;
  localparam int LO_LO  = 0;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_UP_SETUP = 4'd1,
    ST_UP_E     = 4'd2,
    ST_UP_HOLD  = 4'd3,
    ST_GAP      = 4'd4,
    ST_LO_SETUP = 4'd5,
    ST_LO_E     = 4'd6,
    ST_LO_HOLD  = 4'd7,
    ST_WAIT     = 4'd8,
    ST_DONE     = 4'd9
  } lcd_state_e;

  function automatic lcd_state_e state_after(lcd_state_e s);
    case (s)
      ST_IDLE:     return ST_UP_SETUP;
      ST_UP_SETUP: return ST_UP_E;
      ST_UP_E:     return ST_UP_HOLD;
      ST_UP_HOLD:  return ST_GAP;
      ST_GAP:      return ST_LO_SETUP;
      ST_LO_SETUP: return ST_LO_E;
      ST_LO_E:     return ST_LO_HOLD;
      ST_LO_HOLD:  return ST_WAIT;
      ST_WAIT:     return ST_DONE;
      default:     return ST_IDLE;
    endcase
  endfunction

  // SF_D carries the lower nibble from LO_SETUP until the word is finished.
  function automatic logic is_lower_phase(lcd_state_e s);
    return (s == ST_LO_SETUP) || (s == ST_LO_E) || (s == ST_LO_HOLD) ||
           (s == ST_WAIT) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/lcd_instruction_tx_if.sv
// Controller-to-transmitter handshake plus the LCD pin bundle.
interface lcd_instruction_tx_if;
  import lcd_pkg::*;

  logic            next_instruction;
  logic [DB_W-1:0] db;
  logic            LCD_RS;
  logic            LCD_RW;
  logic            LCD_E;
  logic [3:0]      SF_D;
  logic            done;

  modport master (
    output next_instruction, db,
    input  LCD_RS, LCD_RW, LCD_E, SF_D, done
  );

  modport slave (
    input  next_instruction, db,
    output LCD_RS, LCD_RW, LCD_E, SF_D, done
  );

endinterface

// File: rtl/lcd_instruction_tx.sv
// Sends one {RS,RW,D7..D0} word to the LCD as two nibbles with the
// Spartan-3E setup / enable / hold / gap / settle timing.
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | bus quiet, waiting for next_instruction
// ST_UP_SETUP | upper nibble + RS/RW on the bus, E low
// ST_UP_E     | E high for the upper nibble
// ST_UP_HOLD  | E low, upper nibble still held
// ST_GAP      | inter-nibble gap
// ST_LO_SETUP | lower nibble on the bus, E low
// ST_LO_E     | E high for the lower nibble
// ST_LO_HOLD  | E low, lower nibble still held
// ST_WAIT     | instruction settle time
// ST_DONE     | done pulse; also takes a back-to-back strobe
module lcd_instruction_tx #(
  parameter int unsigned SETUP_CYC      = lcd_pkg::SETUP_CYC,
  parameter int unsigned E_HIGH_CYC     = lcd_pkg::E_HIGH_CYC,
  parameter int unsigned HOLD_CYC       = lcd_pkg::HOLD_CYC,
  parameter int unsigned NIBBLE_GAP_CYC = lcd_pkg::NIBBLE_GAP_CYC,
  parameter int unsigned INSTR_WAIT_CYC = lcd_pkg::INSTR_WAIT_CYC
) (
  input logic                 clk,
  input logic                 reset,
  lcd_instruction_tx_if.slave lcd
);
  import lcd_pkg::*;

  lcd_state_e      state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [DB_W-1:0]  word, nxt_word;

  // Counter is loaded with (duration - 1) on entry and advances at zero.
  function automatic logic [CNT_W-1:0] dur_m1(lcd_state_e s);
    int unsigned n;
    case (s)
      ST_UP_SETUP, ST_LO_SETUP: n = SETUP_CYC;
      ST_UP_E, ST_LO_E:         n = E_HIGH_CYC;
      ST_UP_HOLD, ST_LO_HOLD:   n = HOLD_CYC;
      ST_GAP:                   n = NIBBLE_GAP_CYC;
      ST_WAIT:                  n = INSTR_WAIT_CYC;
      default:                  n = 1;
    endcase
    return CNT_W'(n - 1);
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_word  = word;
    if (state == ST_IDLE || state == ST_DONE) begin
      if (lcd.next_instruction) begin
        nxt_state = ST_UP_SETUP;
        nxt_cnt   = dur_m1(ST_UP_SETUP);
        nxt_word  = lcd.db;
      end else begin
        nxt_state = ST_IDLE;
        nxt_cnt   = '0;
      end
    end else if (cnt == '0) begin
      nxt_state = state_after(state);
      nxt_cnt   = dur_m1(nxt_state);
    end else begin
      nxt_cnt = cnt - CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      word       <= '0;
      lcd.LCD_E  <= 1'b0;
      lcd.LCD_RS <= 1'b0;
      lcd.LCD_RW <= 1'b0;
      lcd.SF_D   <= 4'h0;
      lcd.done   <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      word      <= nxt_word;
      lcd.LCD_E <= (nxt_state == ST_UP_E) || (nxt_state == ST_LO_E);
      lcd.done  <= (nxt_state == ST_DONE);
      if (nxt_state == ST_IDLE) begin
        lcd.LCD_RS <= 1'b0;
        lcd.LCD_RW <= 1'b0;
        lcd.SF_D   <= 4'h0;
      end else begin
        lcd.LCD_RS <= nxt_word[RS_BIT];
        lcd.LCD_RW <= nxt_word[RW_BIT];
        lcd.SF_D   <= is_lower_phase(nxt_state) ? nxt_word[LO_HI:LO_LO]
                                                : nxt_word[UP_HI:UP_LO];
      end
    end
  end

endmodule

// File: tb/tb_lcd_instruction_tx.sv
// Random and directed stimulus for lcd_instruction_tx, checked every cycle
// against a cycle-index reference of the nibble timing.
`timescale 1ns/1ps
module tb_lcd_instruction_tx;
  import lcd_pkg::*;

  localparam int S  = SETUP_CYC;
  localparam int EH = E_HIGH_CYC;
  localparam int H  = HOLD_CYC;
  localparam int G  = NIBBLE_GAP_CYC;
  localparam int W  = INSTR_WAIT_CYC;
  localparam int UP_E_FIRST = S + 1;
  localparam int UP_E_LAST  = S + EH;
  localparam int LO_BASE    = S + EH + H + G;
  localparam int LO_E_FIRST = LO_BASE + S + 1;
  localparam int LO_E_LAST  = LO_BASE + S + EH;
  localparam int TOTAL      = 2 * (S + EH + H) + G + W;
  localparam int DONE_K     = TOTAL + 1;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  lcd_instruction_tx_if bus ();

  lcd_instruction_tx dut (
    .clk   (clk),
    .reset (reset),
    .lcd   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: mk = cycle index within the current word (0 = idle)
  int          mk = 0;
  logic [9:0]  mw = '0;
  int          n_done_dut = 0, n_done_exp = 0;
  int          n_pulse_dut = 0, n_pulse_exp = 0;
  logic        prev_e = 1'b0;
  logic [3:0]  prev_sfd = 4'h0;
  int          elen = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_outs(int k, logic [9:0] w);
    logic e, d;
    logic [3:0] nib;
    if (k == 0) return 8'h00;
    e   = (k >= UP_E_FIRST && k <= UP_E_LAST) || (k >= LO_E_FIRST && k <= LO_E_LAST);
    d   = (k == DONE_K);
    nib = (k > LO_BASE) ? w[3:0] : w[7:4];
    return {w[9], w[8], e, d, nib};
  endfunction

  function automatic logic [7:0] dut_outs();
    return {bus.LCD_RS, bus.LCD_RW, bus.LCD_E, bus.done, bus.SF_D};
  endfunction

  task automatic check_outputs();
    check_val($sformatf("outs k=%0d", mk), dut_outs(), exp_outs(mk, mw));
    if (bus.LCD_E && prev_e) check_val("sfd_stable_during_e", bus.SF_D, prev_sfd);
    if (bus.LCD_E) begin
      if (!prev_e) n_pulse_dut++;
      elen++;
    end else if (prev_e) begin
      check_val("e_pulse_width", elen, EH);
      elen = 0;
    end
    if (bus.done) n_done_dut++;
    if (mk == DONE_K) n_done_exp++;
    if (mk == UP_E_FIRST || mk == LO_E_FIRST) n_pulse_exp++;
    prev_e   = bus.LCD_E;
    prev_sfd = bus.SF_D;
  endtask

  // One clock: check the current period, drive inputs, advance the model.
  task automatic cycle(input logic ni_v, input logic [9:0] db_v);
    @(negedge clk);
    check_outputs();
    bus.next_instruction = ni_v;
    bus.db               = db_v;
    if (mk == 0 || mk == DONE_K) begin
      if (ni_v) begin
        mk = 1;
        mw = db_v;
      end else begin
        mk = 0;
      end
    end else begin
      mk++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 10'($urandom));
  endtask

  task automatic issue(input logic [9:0] v);
    cycle(1'b1, v);
  endtask

  initial begin
    reset = 1'b1;
    bus.next_instruction = 1'b0;
    bus.db = '0;
    #100;
    check_val("reset_outs", dut_outs(), 8'h00);
    #5 reset = 1'b0;

    idle(3);

    // basic instruction, then a second one 50 us after the first accept
    issue(10'b00_1010_0101);
    idle(2499);
    issue(10'b00_1111_0000);
    idle(TOTAL + 5);

    // data write
    issue(10'b10_0100_0001);
    idle(TOTAL + 3);

    // strobe while busy must be ignored
    issue(10'b01_0011_1100);
    idle(499);
    cycle(1'b1, 10'b10_1110_0111);
    idle(TOTAL + 3 - 500);

    // next_instruction held high: back-to-back words
    issue(10'b11_0110_1001);
    for (int i = 0; i < 2 * DONE_K + 2; i++) cycle(1'b1, (i < DONE_K) ? 10'h19C : 10'h2E3);
    idle(TOTAL + 3);

    // reset in the middle of the upper E pulse
    issue(10'b00_1000_1111);
    idle(7);
    @(negedge clk);
    check_outputs();
    #2 reset = 1'b1;
    #1;
    check_val("async_e_drop", bus.LCD_E, 1'b0);
    check_val("async_reset_outs", dut_outs(), 8'h00);
    #1 reset = 1'b0;
    mk = 0;
    prev_e = 1'b0;
    elen = 0;
    bus.next_instruction = 1'b0;
    idle(3);
    issue(10'b01_0101_1010);
    idle(TOTAL + 3);

    // random traffic with occasional strobes, some landing while busy
    for (int i = 0; i < 12000; i++)
      cycle(($urandom_range(0, 299) == 0), 10'($urandom));
    idle(TOTAL + 3);

    check_val("done_count", n_done_dut, n_done_exp);
    check_val("e_pulse_count", n_pulse_dut, n_pulse_exp);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
